vote_recorder: RTL
==================

# vote_recorder

Upstream stage of the LED mode controller: converts four raw candidate push-buttons into debounced, one-vote-per-press events. It maintains the four 8-bit per-candidate vote tallies and the `vote_casted` acknowledge that the mode controller consumes. Votes are accepted only in voting mode (`mode` = 0). Tallies saturate at 255.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized cycles required to accept a press; legal range ≥ 2.
- `HOLD_CYCLES`, default 100: number of cycles `vote_casted` stays high per accepted vote; legal range ≥ 1.

Ports:
- `clk` input 1: single clock; all state is on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `mode` input 1: 0 = voting, 1 = display. Synchronous to `clk`.
- `button1`..`button4` input 1 each: raw candidate buttons. Asynchronous and bouncy.
- `candidate1_rcvd_votes`..`candidate4_rcvd_votes` output 8 each: registered tallies.
- `vote_casted` output 1: registered; high while an accepted vote is being acknowledged.

## Operation
- Each button passes through its own 2-flop synchronizer. `s[4:1]` denotes the synchronizer outputs.
- The FSM has four states: IDLE, DEBOUNCE, CAST, WAIT_RELEASE. It also holds:
  - a latched one-hot candidate `sel[4:1]`;
  - a debounce counter sized to hold `DEBOUNCE_CYCLES-1`;
  - a hold counter sized to hold `HOLD_CYCLES-1`.
- IDLE transitions:
  - `mode`=1 or `s`=0 → stay in IDLE.
  - `mode`=0 and `s` one-hot → DEBOUNCE, with `sel`←`s` and debounce count←0.
  - `mode`=0 and more than one bit of `s` set → WAIT_RELEASE (multi-press rejected, no vote).
- DEBOUNCE transitions:
  - `s`==`sel` and `mode`=0: increment the debounce count.
  - `s`==`sel`, `mode`=0 and count == `DEBOUNCE_CYCLES-1`: accept the press.
    - If the selected tally is < 255: increment it by 1, set `vote_casted`←1 and hold count←0, go to CAST.
    - If the selected tally is 255: tally unchanged, `vote_casted` stays 0, go to WAIT_RELEASE.
  - `s`=0: return to IDLE (glitch, no vote).
  - `s`≠`sel` and `s`≠0 (another button added or swapped), or `mode`=1: go to WAIT_RELEASE (no vote).
- CAST:
  - `vote_casted` stays high. The hold count increments each cycle.
  - When hold count == `HOLD_CYCLES-1`, `vote_casted`←0 and go to WAIT_RELEASE.
  - `mode` and buttons are ignored in CAST.
- WAIT_RELEASE: stay until `s`==0 on any cycle, then go to IDLE.
  - One vote per press; holding a button never produces a second vote.
- At most one tally changes per accepted vote. Tallies never decrement and never wrap. All tally arithmetic is 8-bit with a saturation check.

## Timing
- Reset (`rst`=0) immediately, without waiting for a clock edge, does all of the following:
  - FSM→IDLE;
  - all four tallies→0;
  - `vote_casted`→0;
  - synchronizers, `sel` and both counters→0.
- Reset asserted mid-DEBOUNCE or mid-CAST discards the in-progress vote. A tally already incremented is cleared by the reset itself.
- Latency, with the button stable from clock edge E0:
  - `s` high after edge E1;
  - DEBOUNCE entered at E2;
  - CAST entered at E(2+`DEBOUNCE_CYCLES`), which is also the edge where the tally and `vote_casted` update together.
  - With default parameters, the update happens at E18.
- `vote_casted` is high for exactly `HOLD_CYCLES` clock cycles.
- The earliest next vote begins debouncing 2 edges after `s` returns to 0 (WAIT_RELEASE→IDLE→DEBOUNCE).
- A bounce shorter than `DEBOUNCE_CYCLES` cycles never produces a vote.

## Test plan
- Reset, then hold `button2` for 40 cycles in `mode`=0 with defaults:
  - `candidate2_rcvd_votes` goes 0→1 at E18;
  - `vote_casted` is high for exactly 100 cycles;
  - other tallies stay 0.
- Hold `button1` continuously for 500 cycles, release, then press again:
  - exactly 1 vote after the first hold;
  - exactly 2 after the second press.
- Toggle `button3` high for 10 cycles, low for 1, repeatedly, for 200 cycles: no vote and `vote_casted` never rises. Then hold it steady: tally3=1.
- Press `button1` and `button4` on the same edge and hold for 50 cycles: all tallies remain 0 and `vote_casted` stays 0. Release both, press `button4` alone: tally4=1.
- Cast 255 votes for candidate 2, then press once more: tally stays 255 and `vote_casted` stays 0 for that press.
- Assert `rst`=0 mid-CAST, 5 cycles after `vote_casted` rises: all tallies and `vote_casted` read 0 before the next clock edge. Pressing with `mode`=1 produces no vote.

Source files
------------

// File: rtl/vote_recorder.sv
// Debounced four-candidate vote recorder: one vote per clean single-button press
// while in voting mode, with saturating 8-bit tallies and a timed acknowledge.
module vote_recorder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic       button4,
    output logic [7:0] candidate1_rcvd_votes,
    output logic [7:0] candidate2_rcvd_votes,
    output logic [7:0] candidate3_rcvd_votes,
    output logic [7:0] candidate4_rcvd_votes,
    output logic       vote_casted
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_DEBOUNCE     = 2'd1,
        ST_CAST         = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } state_t;

    function automatic logic is_onehot(input logic [3:0] v);
        return ($countones(v) == 32'sd1);
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    state_t        state_q, state_d;
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [3:0]    sel_q, sel_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          vote_q, vote_d;
    logic [7:0]    tally_q [4];
    logic [7:0]    tally_d [4];

    logic [3:0]    s;
    logic [1:0]    sel_idx;
    logic [7:0]    sel_tally;

    assign s         = sync2_q;
    assign sel_idx   = onehot_to_idx(sel_q);
    assign sel_tally = tally_q[sel_idx];

    // Two-flop synchronizer stage inputs for the raw buttons.
    always_comb begin
        sync1_d = {button4, button3, button2, button1};
        sync2_d = sync1_q;
    end

    // Next-state, counter and tally update logic.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        vote_d     = vote_q;
        tally_d    = tally_q;
        case (state_q)
            ST_IDLE: begin
                if (mode || (s == 4'd0)) begin
                    state_d = ST_IDLE;
                end else if (is_onehot(s)) begin
                    state_d   = ST_DEBOUNCE;
                    sel_d     = s;
                    deb_cnt_d = '0;
                end else begin
                    state_d = ST_WAIT_RELEASE;
                end
            end
            ST_DEBOUNCE: begin
                if ((s == sel_q) && !mode) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        // A saturated tally still consumes the press but gives no acknowledge.
                        if (sel_tally != 8'd255) begin
                            tally_d[sel_idx] = sel_tally + 8'd1;
                            vote_d           = 1'b1;
                            hold_cnt_d       = '0;
                            state_d          = ST_CAST;
                        end else begin
                            state_d = ST_WAIT_RELEASE;
                        end
                    end else begin
                        deb_cnt_d = deb_cnt_q + DW'(1);
                    end
                end else if (s == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_RELEASE;
                end
            end
            ST_CAST: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    vote_d  = 1'b0;
                    state_d = ST_WAIT_RELEASE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            ST_WAIT_RELEASE: begin
                if (s == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_RELEASE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                vote_d  = 1'b0;
            end
        endcase
    end

    // State, synchronizer, counter and tally registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            sync1_q    <= 4'd0;
            sync2_q    <= 4'd0;
            sel_q      <= 4'd0;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            vote_q     <= 1'b0;
            tally_q    <= '{default: 8'd0};
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sel_q      <= sel_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            vote_q     <= vote_d;
            tally_q    <= tally_d;
        end
    end

    assign candidate1_rcvd_votes = tally_q[0];
    assign candidate2_rcvd_votes = tally_q[1];
    assign candidate3_rcvd_votes = tally_q[2];
    assign candidate4_rcvd_votes = tally_q[3];
    assign vote_casted           = vote_q;

endmodule
